// File: rtl/time_op_controller.sv
// Minute/second time registers with 1 Hz prescaler.
// Applies each encoder command once and acknowledges it with encoder_reset.
module time_op_controller #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] operate,
  output logic       encoder_reset,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       sec_tick
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    ACK
  } state_t;

  state_t state, state_n;
  logic [1:0] op_r, op_n;
  logic [PW-1:0] pre, pre_n;
  logic [5:0] sec_n, min_n, min_add;
  logic [6:0] msum;
  logic tick, carry, tick_n, er_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_r          <= 2'b00;
      pre           <= '0;
      sec           <= 6'd0;
      min           <= 6'd0;
      sec_tick      <= 1'b0;
      encoder_reset <= 1'b0;
    end else begin
      state         <= state_n;
      op_r          <= op_n;
      pre           <= pre_n;
      sec           <= sec_n;
      min           <= min_n;
      sec_tick      <= tick_n;
      encoder_reset <= er_n;
    end
  end

  always_comb begin
    tick    = (pre == PRE_MAX);
    carry   = tick && (sec == 6'd59);
    pre_n   = tick ? '0 : pre + PW'(1);
    sec_n   = tick ? (carry ? 6'd0 : sec + 6'd1) : sec;
    min_n   = carry ? ((min == 6'd59) ? 6'd0 : min + 6'd1) : min;
    // Minute add folds in a coincident seconds carry
    msum    = {1'b0, min} + 7'd1 + {6'd0, carry};
    min_add = (msum >= 7'd60) ? 6'(msum - 7'd60) : msum[5:0];
    tick_n  = tick;
    state_n = state;
    op_n    = op_r;
    er_n    = encoder_reset;
    unique case (state)
      IDLE: begin
        if (operate != 2'b00) begin
          op_n    = operate;
          state_n = APPLY;
        end
      end
      APPLY: begin
        state_n = ACK;
        er_n    = 1'b1;
        unique case (op_r)
          2'b10: min_n = min_add;
          2'b01: begin
            sec_n  = 6'd0;
            pre_n  = '0;
            min_n  = min;
            tick_n = 1'b0;
          end
          2'b11: begin
            sec_n  = 6'd0;
            min_n  = 6'd0;
            pre_n  = '0;
            tick_n = 1'b0;
          end
          default: ;
        endcase
      end
      ACK: begin
        if (operate == 2'b00) begin
          er_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_time_op_controller.sv
// Directed bench for time_op_controller with CLK_HZ=4.
// Time is positioned via minute adds and seconds-zero commands.
module tb_time_op_controller;

  logic       clk;
  logic       rst_n;
  logic [1:0] operate;
  logic       encoder_reset;
  logic [5:0] sec;
  logic [5:0] min;
  logic       sec_tick;

  int compared = 0;
  int mismatched = 0;
  int ticks = 0;
  int er_hits = 0;

  time_op_controller #(.CLK_HZ(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .operate(operate),
    .encoder_reset(encoder_reset),
    .sec(sec),
    .min(min),
    .sec_tick(sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (sec_tick) ticks++;
      if (encoder_reset) er_hits++;
    end
  endtask

  // Three-edge command with handshake checks; APPLY is the second edge
  task automatic cmd(input logic [1:0] code);
    operate = code;
    step(1);
    check("cmd_er_low", encoder_reset, 0);
    step(1);
    check("cmd_er_high", encoder_reset, 1);
    operate = 2'b00;
    step(1);
    check("cmd_er_fall", encoder_reset, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    operate = 2'b00;
    #2 rst_n = 1'b0;
    step(2);
    check("rst_sec", sec, 0);
    check("rst_min", min, 0);
    check("rst_er", encoder_reset, 0);
    check("rst_tick", sec_tick, 0);

    // 1: free run through a full hour
    rst_n = 1'b1;
    ticks = 0;
    er_hits = 0;
    step(3);
    check("first_tick_early", sec, 0);
    step(1);
    check("first_tick", sec, 1);
    check("first_tick_pulse", sec_tick, 1);
    step(232);
    check("run_59s", sec, 59);
    step(4);
    check("run_1m_sec", sec, 0);
    check("run_1m_min", min, 1);
    step(14156);
    check("run_5959_min", min, 59);
    check("run_5959_sec", sec, 59);
    step(4);
    check("wrap_min", min, 0);
    check("wrap_sec", sec, 0);
    check("tick_count", ticks, 3600);
    check("er_never", er_hits, 0);

    // 2: reach 05:10 then minute add
    for (int i = 0; i < 5; i++) cmd(2'b10);
    cmd(2'b01);
    step(39);
    check("pos_0510_min", min, 5);
    check("pos_0510_sec", sec, 10);
    cmd(2'b10);
    check("madd_min", min, 6);
    check("madd_sec", sec, 10);

    // 3: held button at 07:00
    cmd(2'b10);
    cmd(2'b01);
    check("pos_0700_min", min, 7);
    check("pos_0700_sec", sec, 0);
    operate = 2'b10;
    step(1);
    check("hold_er_low", encoder_reset, 0);
    step(1);
    check("hold_er_up", encoder_reset, 1);
    check("hold_min_up", min, 8);
    step(48);
    check("hold_er_held", encoder_reset, 1);
    check("hold_min_once", min, 8);
    operate = 2'b00;
    step(1);
    check("hold_er_fall", encoder_reset, 0);
    check("hold_min_end", min, 8);

    // 4: seconds-to-zero on the terminal count
    cmd(2'b11);
    check("clr_min", min, 0);
    check("clr_sec", sec, 0);
    for (int i = 0; i < 3; i++) cmd(2'b10);
    cmd(2'b01);
    step(237);
    check("pos_0359_min", min, 3);
    check("pos_0359_sec", sec, 59);
    operate = 2'b01;
    step(1);
    check("s0_sec_pre", sec, 59);
    step(1);
    check("s0_sec", sec, 0);
    check("s0_min", min, 3);
    check("s0_tick_gone", sec_tick, 0);
    check("s0_er", encoder_reset, 1);
    operate = 2'b00;
    step(1);
    check("s0_tick_after", sec_tick, 0);
    step(2);
    check("s0_no_early", sec, 0);
    step(1);
    check("s0_next_tick", sec, 1);
    check("s0_next_pulse", sec_tick, 1);

    // 5: minute add coincident with carry
    for (int i = 0; i < 55; i++) cmd(2'b10);
    cmd(2'b01);
    step(237);
    check("pos_5859_min", min, 58);
    check("pos_5859_sec", sec, 59);
    operate = 2'b10;
    step(2);
    check("mc_min", min, 0);
    check("mc_sec", sec, 0);
    check("mc_tick", sec_tick, 1);
    check("mc_er", encoder_reset, 1);
    operate = 2'b00;
    step(1);
    check("mc_er_fall", encoder_reset, 0);

    // 6: async reset during ACK
    for (int i = 0; i < 12; i++) cmd(2'b10);
    cmd(2'b01);
    step(135);
    check("pos_1234_min", min, 12);
    check("pos_1234_sec", sec, 34);
    operate = 2'b11;
    step(2);
    check("fr_min", min, 0);
    check("fr_sec", sec, 0);
    check("fr_er", encoder_reset, 1);
    step(1);
    check("fr_er_ack", encoder_reset, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_er", encoder_reset, 0);
    check("ar_sec", sec, 0);
    check("ar_min", min, 0);
    check("ar_tick", sec_tick, 0);
    step(2);
    check("ar_er_hold", encoder_reset, 0);
    rst_n = 1'b1;
    step(1);
    check("re_er_low", encoder_reset, 0);
    step(1);
    check("re_er_high", encoder_reset, 1);
    check("re_min", min, 0);
    check("re_sec", sec, 0);
    step(2);
    check("re_er_held", encoder_reset, 1);
    operate = 2'b00;
    step(1);
    check("re_er_fall", encoder_reset, 0);
    check("re_min_end", min, 0);
    check("re_sec_end", sec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
